// File: rtl/uart_cmd_pkg.sv
// Shared command/response byte codes and FSM state encoding for uart_cmd_resp.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_PING  = 8'h50;   // 'P'
    localparam logic [7:0] CMD_READ  = 8'h52;   // 'R'
    localparam logic [7:0] CMD_WRITE = 8'h57;   // 'W'

    localparam logic [7:0] RSP_OK    = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;   // '?'
    localparam logic [3:0] RSP_READ_HI = 4'h3;  // read reply is ASCII '0'..'?'

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ARG = 2'd1,
        SEND     = 2'd2,
        GAP      = 2'd3
    } state_e;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Argument-wait timer: counts enabled cycles, pulses expire_o combinationally in the CYCLES-th one.
// No backpressure; clr_i wins over en_i and restarts the count from zero.
module uart_timeout_cnt #(
    parameter int CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_resp.sv
// Single-byte UART command decoder ('P' ping, 'R' read switches, 'W' write LEDs) with one response byte per command.
// tx_en_o fires the cycle after the completing byte when tx_ready_i is high; bytes arriving while a response is pending are dropped as overrun.
module uart_cmd_resp
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ_Hz = 27000000,
    parameter int TIMEOUT_MS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_vld_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_err_i,
    input  logic [3:0] switch_i,
    output logic [3:0] led_o,
    input  logic       tx_ready_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       cmd_err_o
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_Hz / 1000 * TIMEOUT_MS;

    state_e     state_q, state_d;
    logic [3:0] led_q, led_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       cmd_err_q, cmd_err_d;
    logic       gap_q, gap_d;
    logic       tmo_clr, tmo_expire;

    uart_timeout_cnt #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (state_q == WAIT_ARG),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        cmd_err_d = 1'b0;
        tmo_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_vld_i) begin
                    if (rx_err_i) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        case (rx_data_i)
                            CMD_PING: begin
                                tx_data_d = RSP_OK;
                                state_d   = SEND;
                            end
                            CMD_READ: begin
                                tx_data_d = {RSP_READ_HI, switch_i};
                                state_d   = SEND;
                            end
                            CMD_WRITE: begin
                                tmo_clr = 1'b1;
                                state_d = WAIT_ARG;
                            end
                            default: begin
                                tx_data_d = RSP_ERR;
                                cmd_err_d = 1'b1;
                                state_d   = SEND;
                            end
                        endcase
                    end
                end
            end
            WAIT_ARG: begin
                // A byte landing in the expiry cycle still counts as the argument.
                if (rx_vld_i) begin
                    if (rx_err_i) begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        led_d     = rx_data_i[3:0];
                        tx_data_d = RSP_OK;
                        state_d   = SEND;
                    end
                end else if (tmo_expire) begin
                    tx_data_d = RSP_ERR;
                    cmd_err_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                cmd_err_d = rx_vld_i;
                if (tx_ready_i) begin
                    gap_d   = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cmd_err_d = rx_vld_i;
                if (gap_q) begin
                    state_d = IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            led_q     <= 4'h0;
            tx_data_q <= 8'h00;
            cmd_err_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            tx_data_q <= tx_data_d;
            cmd_err_q <= cmd_err_d;
            gap_q     <= gap_d;
        end
    end

    // Combinational so the pulse lands one cycle after the completing byte; gated so reset mid-SEND never fires it.
    assign tx_en_o   = (state_q == SEND) && tx_ready_i && !rst;
    assign led_o     = led_q;
    assign tx_data_o = tx_data_q;
    assign cmd_err_o = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Table-driven command checks plus hand-written timeout, backpressure and reset sequences.
module tb_uart_cmd_resp;

    localparam int CLK_HZ = 50000;
    localparam int TMO_MS = 1;
    localparam int TMO_CYC = CLK_HZ / 1000 * TMO_MS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_vld_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_err_i = 1'b0;
    logic [3:0] switch_i = 4'h0;
    logic [3:0] led_o;
    logic       tx_ready_i = 1'b1;
    logic       tx_en_o;
    logic [7:0] tx_data_o;
    logic       cmd_err_o;

    uart_cmd_resp #(
        .CLK_FREQ_Hz (CLK_HZ),
        .TIMEOUT_MS  (TMO_MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_vld_i   (rx_vld_i),
        .rx_data_i  (rx_data_i),
        .rx_err_i   (rx_err_i),
        .switch_i   (switch_i),
        .led_o      (led_o),
        .tx_ready_i (tx_ready_i),
        .tx_en_o    (tx_en_o),
        .tx_data_o  (tx_data_o),
        .cmd_err_o  (cmd_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic       err;
        logic       has_arg;
        logic [7:0] arg;
        logic [3:0] sw;
        logic       exp_tx;
        logic       exp_err;
        logic [3:0] exp_led;
    } row_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int tx_seen  = 0;
    int err_seen = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every tx_en_o pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (cmd_err_o === 1'b1) err_seen++;
        if (tx_en_o === 1'b1) begin
            tx_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_tx: got tx_data 0x%0h with no response pending", tx_data_o);
            end else begin
                chk("tx_data", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    row_t rows[9];
    int   tx0, err0, k;
    logic [3:0] led_save;

    initial begin
        rows[0] = '{8'h50, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0};
        rows[1] = '{8'h52, 1'b0, 1'b0, 8'h00, 4'hA, 1'b1, 1'b0, 4'h0};
        rows[2] = '{8'h52, 1'b0, 1'b0, 8'h00, 4'h5, 1'b1, 1'b0, 4'h0};
        rows[3] = '{8'h57, 1'b0, 1'b1, 8'h05, 4'h0, 1'b1, 1'b0, 4'h5};
        rows[4] = '{8'h41, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'h5};
        rows[5] = '{8'h50, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 4'h5};
        rows[6] = '{8'h57, 1'b0, 1'b1, 8'hFC, 4'h0, 1'b1, 1'b0, 4'hC};
        rows[7] = '{8'h52, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 4'hC};
        rows[8] = '{8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'hC};

        repeat (3) tick();
        @(negedge clk);
        chk("rst_led", {28'h0, led_o}, 32'h0);
        chk("rst_tx_en", {31'h0, tx_en_o}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        chk("rst_cmd_err", {31'h0, cmd_err_o}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            rx_vld_i  = 1'b1;
            rx_data_i = rows[i].cmd;
            rx_err_i  = rows[i].err;
            switch_i  = rows[i].sw;
            if (rows[i].has_arg) exp_q.push_back(8'h4B);
            else if (rows[i].exp_tx) begin
                if (rows[i].cmd == 8'h50) exp_q.push_back(8'h4B);
                else if (rows[i].cmd == 8'h52) exp_q.push_back({4'h3, rows[i].sw});
                else exp_q.push_back(8'h3F);
            end
            tick();
            rx_vld_i = 1'b0;
            rx_err_i = 1'b0;
            switch_i = ~rows[i].sw;
            @(negedge clk);
            if (rows[i].has_arg) begin
                chk($sformatf("row%0d_w_no_tx", i), {31'h0, tx_en_o}, 32'h0);
                chk($sformatf("row%0d_w_no_err", i), {31'h0, cmd_err_o}, 32'h0);
                tick();
                rx_vld_i  = 1'b1;
                rx_data_i = rows[i].arg;
                tick();
                rx_vld_i = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("row%0d_tx_en", i), {31'h0, tx_en_o}, {31'h0, rows[i].exp_tx});
            chk($sformatf("row%0d_cmd_err", i), {31'h0, cmd_err_o}, {31'h0, rows[i].exp_err});
            repeat (5) tick();
            chk($sformatf("row%0d_led", i), {28'h0, led_o}, {28'h0, rows[i].exp_led});
        end

        // Timeout: '?' appears one cycle after the TMO_CYC-th waiting cycle, LEDs untouched.
        tx0 = tx_seen; err0 = err_seen; led_save = led_o;
        rx_vld_i = 1'b1; rx_data_i = 8'h57;
        exp_q.push_back(8'h3F);
        tick();
        rx_vld_i = 1'b0;
        k = 0;
        for (int c = 1; c <= 4 * TMO_CYC; c++) begin
            @(negedge clk);
            if (tx_en_o === 1'b1) begin
                k = c;
                break;
            end
        end
        chk("timeout_latency", k, TMO_CYC + 1);
        repeat (5) tick();
        chk("timeout_err_pulses", err_seen - err0, 1);
        chk("timeout_tx_count", tx_seen - tx0, 1);
        chk("timeout_led", {28'h0, led_o}, {28'h0, led_save});

        // Argument arriving in the expiry cycle beats the timeout.
        err0 = err_seen;
        rx_vld_i = 1'b1; rx_data_i = 8'h57;
        tick();
        rx_vld_i = 1'b0;
        repeat (TMO_CYC - 1) tick();
        rx_vld_i = 1'b1; rx_data_i = 8'h07;
        exp_q.push_back(8'h4B);
        tick();
        rx_vld_i = 1'b0;
        @(negedge clk);
        chk("tie_tx_en", {31'h0, tx_en_o}, 32'h1);
        repeat (5) tick();
        chk("tie_no_err", err_seen - err0, 0);
        chk("tie_led", {28'h0, led_o}, 32'h7);

        // Transmitter busy for 100 cycles with an overrun byte in the middle.
        tx0 = tx_seen; err0 = err_seen;
        tx_ready_i = 1'b0;
        rx_vld_i = 1'b1; rx_data_i = 8'h50;
        exp_q.push_back(8'h4B);
        tick();
        rx_vld_i = 1'b0;
        repeat (50) tick();
        rx_vld_i = 1'b1; rx_data_i = 8'h52;
        tick();
        rx_vld_i = 1'b0;
        repeat (49) tick();
        chk("hold_no_tx", tx_seen - tx0, 0);
        chk("hold_overrun_err", err_seen - err0, 1);
        tx_ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release_tx_en", {31'h0, tx_en_o}, 32'h1);
        repeat (6) tick();
        chk("hold_single_tx", tx_seen - tx0, 1);

        // Reset while waiting for the write argument.
        rx_vld_i = 1'b1; rx_data_i = 8'h57;
        tick();
        rx_vld_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rstw_led", {28'h0, led_o}, 32'h0);
        chk("rstw_tx_en", {31'h0, tx_en_o}, 32'h0);
        chk("rstw_tx_data", {24'h0, tx_data_o}, 32'h0);
        chk("rstw_cmd_err", {31'h0, cmd_err_o}, 32'h0);
        tick();
        rst = 1'b0;
        rx_vld_i = 1'b1; rx_data_i = 8'h05;
        exp_q.push_back(8'h3F);
        tick();
        rx_vld_i = 1'b0;
        @(negedge clk);
        chk("rstw_after_err", {31'h0, cmd_err_o}, 32'h1);
        chk("rstw_after_tx_en", {31'h0, tx_en_o}, 32'h1);
        repeat (5) tick();
        chk("rstw_after_led", {28'h0, led_o}, 32'h0);

        // Reset while a response is stalled in SEND: it must never go out.
        tx0 = tx_seen;
        tx_ready_i = 1'b0;
        rx_vld_i = 1'b1; rx_data_i = 8'h50;
        tick();
        rx_vld_i = 1'b0;
        repeat (3) tick();
        tx_ready_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rsts_tx_en", {31'h0, tx_en_o}, 32'h0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rsts_no_tx", tx_seen - tx0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
